// File: rtl/ct_lsu_dcache_info_writer_pkg.sv
// Shared LSU definitions for the dcache tag/dirty info writer: FSM and
// request-kind encodings, dirty-array bit layout, tag/index address slices.
package ct_lsu_dcache_info_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_WRITE = 2'd2,
        ST_SWEEP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_REFILL = 2'd0,
        KIND_ST     = 2'd1,
        KIND_SWEEP  = 2'd2
    } req_kind_e;

    // Physical address and tag slice: tag is addr[39:14].
    localparam int DC_ADDR_W    = 40;
    localparam int DC_TAG_W     = 26;
    localparam int IDX_ADDR_LSB = 6;

    // Dirty array layout: {lru, way1 {d,s,v}, way0 {d,s,v}}.
    localparam int DIRTY_W       = 7;
    localparam int DIRTY_FLD_W   = 3;
    localparam int DIRTY_W0_LSB  = 0;
    localparam int DIRTY_W1_LSB  = 3;
    localparam int DIRTY_LRU_BIT = 6;

    localparam logic [DIRTY_FLD_W-1:0] DIRTY_FLD_ALL   = 3'b111;
    localparam logic [DIRTY_W-1:0]     DIRTY_SWEEP_WEN = 7'b0111111;

    // Index width for a given cache size: 8 bits for 32K, 9 bits for 64K.
    function automatic int dc_idx_w(input int size_kb);
        return (size_kb == 32) ? 8 : 9;
    endfunction

    localparam int DC_IDX_W_64K = dc_idx_w(64);

endpackage

// File: rtl/ct_lsu_dcache_info_writer_if.sv
// Dcache tag/dirty array write bus. The writer is the master; the arrays
// and the dcache info snoopers attach as slaves.
interface ct_lsu_dcache_info_writer_if #(
    parameter int IDX_W = 9,
    parameter int TAG_W = 26
);
    logic [IDX_W-1:0]   dcache_idx;
    logic               dcache_tag_gwen;
    logic [1:0]         dcache_tag_wen;
    logic [2*TAG_W-1:0] dcache_tag_din;
    logic               dcache_dirty_gwen;
    logic [6:0]         dcache_dirty_wen;
    logic [6:0]         dcache_dirty_din;

    modport master (
        output dcache_idx, dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
               dcache_dirty_gwen, dcache_dirty_wen, dcache_dirty_din
    );

    modport slave (
        input  dcache_idx, dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
               dcache_dirty_gwen, dcache_dirty_wen, dcache_dirty_din
    );
endinterface

// File: rtl/ct_lsu_dcache_info_wr_fmt.sv
// Combinational formatter: turns a latched request (kind, way, tag and a
// 3-bit {dirty,share,valid} field enable/value) into tag/dirty array vectors.
module ct_lsu_dcache_info_wr_fmt
    import ct_lsu_dcache_info_writer_pkg::*;
#(
    parameter int TAG_W = DC_TAG_W
) (
    input  req_kind_e                kind,
    input  logic                     way,
    input  logic [TAG_W-1:0]         tag,
    input  logic [DIRTY_FLD_W-1:0]   fld_wen,
    input  logic [DIRTY_FLD_W-1:0]   fld_din,
    output logic                     tag_gwen,
    output logic [1:0]               tag_wen,
    output logic [2*TAG_W-1:0]       tag_din,
    output logic                     dirty_gwen,
    output logic [DIRTY_W-1:0]       dirty_wen,
    output logic [DIRTY_W-1:0]       dirty_din
);

    // Build the write vectors; unused way slices and fields stay zero.
    always_comb begin
        tag_gwen   = 1'b0;
        tag_wen    = 2'b00;
        tag_din    = '0;
        dirty_gwen = 1'b0;
        dirty_wen  = '0;
        dirty_din  = '0;

        case (kind)
            KIND_REFILL: begin
                tag_gwen     = 1'b1;
                tag_wen[way] = 1'b1;
                if (way) begin
                    tag_din[TAG_W +: TAG_W] = tag;
                end else begin
                    tag_din[0 +: TAG_W] = tag;
                end
                dirty_gwen               = 1'b1;
                // LRU points at the way that was not just filled.
                dirty_wen[DIRTY_LRU_BIT] = 1'b1;
                dirty_din[DIRTY_LRU_BIT] = ~way;
            end
            KIND_ST: begin
                dirty_gwen = 1'b1;
            end
            KIND_SWEEP: begin
                dirty_gwen = 1'b1;
                dirty_wen  = DIRTY_SWEEP_WEN;
            end
            default: begin
            end
        endcase

        // Refill and state change both place the 3-bit field in the way slice.
        if (kind == KIND_REFILL || kind == KIND_ST) begin
            if (way) begin
                dirty_wen[DIRTY_W1_LSB +: DIRTY_FLD_W] = fld_wen;
                dirty_din[DIRTY_W1_LSB +: DIRTY_FLD_W] = fld_din;
            end else begin
                dirty_wen[DIRTY_W0_LSB +: DIRTY_FLD_W] = fld_wen;
                dirty_din[DIRTY_W0_LSB +: DIRTY_FLD_W] = fld_din;
            end
        end
    end

endmodule

// File: rtl/ct_lsu_dcache_info_writer.sv
// Dcache tag/dirty info writer: serialises refill, state-change and
// invalidate-all sweep writes onto the array write bus via the array arbiter.
//
// Handshakes: refill_req_rdy / st_req_rdy are combinational on the matching
// vld and only high in IDLE with no sweep pending; a request transfers in a
// cycle where vld && rdy. arb_req is held until arb_grnt; each grant cycle
// produces exactly one registered write pulse in the following cycle.
module ct_lsu_dcache_info_writer
    import ct_lsu_dcache_info_writer_pkg::*;
#(
    parameter int IDX_W = DC_IDX_W_64K,
    parameter int TAG_W = DC_TAG_W
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  refill_req_vld,
    input  logic [DC_ADDR_W-1:0]  refill_req_addr,
    input  logic                  refill_req_way,
    input  logic                  refill_req_dirty,
    input  logic                  refill_req_share,
    output logic                  refill_req_rdy,
    input  logic                  st_req_vld,
    input  logic [IDX_W-1:0]      st_req_idx,
    input  logic                  st_req_way,
    input  logic [2:0]            st_req_wen,
    input  logic [2:0]            st_req_din,
    output logic                  st_req_rdy,
    input  logic                  inv_all_req,
    output logic                  inv_all_done,
    output logic                  arb_req,
    input  logic                  arb_grnt,
    output logic                  busy,
    output logic [1:0]            dbg_state,
    ct_lsu_dcache_info_writer_if.master dc_if
);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic                   pend_q, pend_d;

    req_kind_e              lat_kind_q, lat_kind_d;
    logic                   lat_way_q, lat_way_d;
    logic [TAG_W-1:0]       lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]       lat_idx_q, lat_idx_d;
    logic [2:0]             lat_wen_q, lat_wen_d;
    logic [2:0]             lat_din_q, lat_din_d;

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   tag_gwen_q, tag_gwen_d;
    logic [1:0]             tag_wen_q, tag_wen_d;
    logic [2*TAG_W-1:0]     tag_din_q, tag_din_d;
    logic                   dirty_gwen_q, dirty_gwen_d;
    logic [DIRTY_W-1:0]     dirty_wen_q, dirty_wen_d;
    logic [DIRTY_W-1:0]     dirty_din_q, dirty_din_d;
    logic                   done_q, done_d;

    req_kind_e              fmt_kind;
    logic                   fmt_tag_gwen;
    logic [1:0]             fmt_tag_wen;
    logic [2*TAG_W-1:0]     fmt_tag_din;
    logic                   fmt_dirty_gwen;
    logic [DIRTY_W-1:0]     fmt_dirty_wen;
    logic [DIRTY_W-1:0]     fmt_dirty_din;

    // Line-offset bits of the refill address play no part in the write.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^refill_req_addr[IDX_ADDR_LSB-1:0];

    // In a sweep the formatter produces the invalidate pattern.
    assign fmt_kind = (state_q == ST_SWEEP) ? KIND_SWEEP : lat_kind_q;

    ct_lsu_dcache_info_wr_fmt #(
        .TAG_W (TAG_W)
    ) u_fmt (
        .kind       (fmt_kind),
        .way        (lat_way_q),
        .tag        (lat_tag_q),
        .fld_wen    (lat_wen_q),
        .fld_din    (lat_din_q),
        .tag_gwen   (fmt_tag_gwen),
        .tag_wen    (fmt_tag_wen),
        .tag_din    (fmt_tag_din),
        .dirty_gwen (fmt_dirty_gwen),
        .dirty_wen  (fmt_dirty_wen),
        .dirty_din  (fmt_dirty_din)
    );

    // Next-state, request acceptance, arbiter request and write-pulse values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q | inv_all_req;
        lat_kind_d     = lat_kind_q;
        lat_way_d      = lat_way_q;
        lat_tag_d      = lat_tag_q;
        lat_idx_d      = lat_idx_q;
        lat_wen_d      = lat_wen_q;
        lat_din_d      = lat_din_q;
        idx_d          = idx_q;
        tag_gwen_d     = 1'b0;
        tag_wen_d      = 2'b00;
        tag_din_d      = '0;
        dirty_gwen_d   = 1'b0;
        dirty_wen_d    = '0;
        dirty_din_d    = '0;
        done_d         = 1'b0;
        refill_req_rdy = 1'b0;
        st_req_rdy     = 1'b0;
        arb_req        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    // The flag is consumed here so a request arriving during
                    // the sweep re-arms it for one further full sweep.
                    state_d = ST_SWEEP;
                    pend_d  = inv_all_req;
                end else if (refill_req_vld) begin
                    refill_req_rdy = 1'b1;
                    lat_kind_d     = KIND_REFILL;
                    lat_way_d      = refill_req_way;
                    lat_tag_d      = refill_req_addr[DC_ADDR_W-1 -: TAG_W];
                    lat_idx_d      = refill_req_addr[IDX_ADDR_LSB +: IDX_W];
                    lat_wen_d      = DIRTY_FLD_ALL;
                    lat_din_d      = {refill_req_dirty, refill_req_share, 1'b1};
                    state_d        = ST_ARB;
                end else if (st_req_vld) begin
                    st_req_rdy = 1'b1;
                    lat_kind_d = KIND_ST;
                    lat_way_d  = st_req_way;
                    lat_tag_d  = '0;
                    lat_idx_d  = st_req_idx;
                    lat_wen_d  = st_req_wen;
                    lat_din_d  = st_req_din;
                    state_d    = ST_ARB;
                end
            end
            ST_ARB: begin
                arb_req = 1'b1;
                if (arb_grnt) begin
                    idx_d        = lat_idx_q;
                    tag_gwen_d   = fmt_tag_gwen;
                    tag_wen_d    = fmt_tag_wen;
                    tag_din_d    = fmt_tag_din;
                    dirty_gwen_d = fmt_dirty_gwen;
                    dirty_wen_d  = fmt_dirty_wen;
                    dirty_din_d  = fmt_dirty_din;
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_SWEEP: begin
                arb_req = 1'b1;
                if (arb_grnt) begin
                    idx_d        = cnt_q;
                    tag_gwen_d   = fmt_tag_gwen;
                    tag_wen_d    = fmt_tag_wen;
                    tag_din_d    = fmt_tag_din;
                    dirty_gwen_d = fmt_dirty_gwen;
                    dirty_wen_d  = fmt_dirty_wen;
                    dirty_din_d  = fmt_dirty_din;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == {IDX_W{1'b1}}) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered array outputs.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            lat_kind_q   <= KIND_REFILL;
            lat_way_q    <= 1'b0;
            lat_tag_q    <= '0;
            lat_idx_q    <= '0;
            lat_wen_q    <= '0;
            lat_din_q    <= '0;
            idx_q        <= '0;
            tag_gwen_q   <= 1'b0;
            tag_wen_q    <= 2'b00;
            tag_din_q    <= '0;
            dirty_gwen_q <= 1'b0;
            dirty_wen_q  <= '0;
            dirty_din_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            lat_kind_q   <= lat_kind_d;
            lat_way_q    <= lat_way_d;
            lat_tag_q    <= lat_tag_d;
            lat_idx_q    <= lat_idx_d;
            lat_wen_q    <= lat_wen_d;
            lat_din_q    <= lat_din_d;
            idx_q        <= idx_d;
            tag_gwen_q   <= tag_gwen_d;
            tag_wen_q    <= tag_wen_d;
            tag_din_q    <= tag_din_d;
            dirty_gwen_q <= dirty_gwen_d;
            dirty_wen_q  <= dirty_wen_d;
            dirty_din_q  <= dirty_din_d;
            done_q       <= done_d;
        end
    end

    assign dc_if.dcache_idx        = idx_q;
    assign dc_if.dcache_tag_gwen   = tag_gwen_q;
    assign dc_if.dcache_tag_wen    = tag_wen_q;
    assign dc_if.dcache_tag_din    = tag_din_q;
    assign dc_if.dcache_dirty_gwen = dirty_gwen_q;
    assign dc_if.dcache_dirty_wen  = dirty_wen_q;
    assign dc_if.dcache_dirty_din  = dirty_din_q;

    assign inv_all_done = done_q;
    assign busy         = (state_q != ST_IDLE) | pend_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ct_lsu_dcache_info_writer.sv
// Directed bench for ct_lsu_dcache_info_writer: refill, state change,
// priority, full invalidate sweep, sweep behind a refill and mid-sweep reset.
module tb_ct_lsu_dcache_info_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_req_vld;
    logic [39:0] refill_req_addr;
    logic        refill_req_way;
    logic        refill_req_dirty;
    logic        refill_req_share;
    logic        refill_req_rdy;
    logic        st_req_vld;
    logic [8:0]  st_req_idx;
    logic        st_req_way;
    logic [2:0]  st_req_wen;
    logic [2:0]  st_req_din;
    logic        st_req_rdy;
    logic        inv_all_req;
    logic        inv_all_done;
    logic        arb_req;
    logic        arb_grnt;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    ct_lsu_dcache_info_writer_if #(.IDX_W(9), .TAG_W(26)) dc_if ();

    ct_lsu_dcache_info_writer #(.IDX_W(9), .TAG_W(26)) dut (
        .forever_cpuclk   (clk),
        .cpurst_b         (rst_n),
        .refill_req_vld   (refill_req_vld),
        .refill_req_addr  (refill_req_addr),
        .refill_req_way   (refill_req_way),
        .refill_req_dirty (refill_req_dirty),
        .refill_req_share (refill_req_share),
        .refill_req_rdy   (refill_req_rdy),
        .st_req_vld       (st_req_vld),
        .st_req_idx       (st_req_idx),
        .st_req_way       (st_req_way),
        .st_req_wen       (st_req_wen),
        .st_req_din       (st_req_din),
        .st_req_rdy       (st_req_rdy),
        .inv_all_req      (inv_all_req),
        .inv_all_done     (inv_all_done),
        .arb_req          (arb_req),
        .arb_grnt         (arb_grnt),
        .busy             (busy),
        .dbg_state        (dbg_state),
        .dc_if            (dc_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int         cyc;
        int         done_cnt;
        int         exp_i;
        logic       g;
        logic       finished;
        logic [8:0] e;

        rst_n            = 1'b0;
        refill_req_vld   = 1'b0;
        refill_req_addr  = '0;
        refill_req_way   = 1'b0;
        refill_req_dirty = 1'b0;
        refill_req_share = 1'b0;
        st_req_vld       = 1'b0;
        st_req_idx       = '0;
        st_req_way       = 1'b0;
        st_req_wen       = '0;
        st_req_din       = '0;
        inv_all_req      = 1'b0;
        arb_grnt         = 1'b0;

        // ---------------- reset state
        step(); step();
        chk("rst_state",      64'(dbg_state), 64'd0);
        chk("rst_busy",       64'(busy), 64'd0);
        chk("rst_arb_req",    64'(arb_req), 64'd0);
        chk("rst_done",       64'(inv_all_done), 64'd0);
        chk("rst_idx",        64'(dc_if.dcache_idx), 64'd0);
        chk("rst_tag_gwen",   64'(dc_if.dcache_tag_gwen), 64'd0);
        chk("rst_dirty_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd0);
        chk("rst_dirty_wen",  64'(dc_if.dcache_dirty_wen), 64'd0);
        rst_n = 1'b1;
        step();

        // ---------------- refill way1, immediate grant
        refill_req_vld   = 1'b1;
        refill_req_addr  = 40'h12_3456_7FC0;
        refill_req_way   = 1'b1;
        refill_req_dirty = 1'b1;
        refill_req_share = 1'b0;
        arb_grnt         = 1'b1;
        #1;
        chk("r1_refill_rdy", 64'(refill_req_rdy), 64'd1);
        chk("r1_st_rdy",     64'(st_req_rdy), 64'd0);
        step();
        refill_req_vld = 1'b0;
        chk("r1_state_arb",  64'(dbg_state), 64'd1);
        chk("r1_arb_req",    64'(arb_req), 64'd1);
        chk("r1_no_early",   64'(dc_if.dcache_dirty_gwen), 64'd0);
        step();
        chk("r1_tag_gwen",   64'(dc_if.dcache_tag_gwen), 64'd1);
        chk("r1_tag_wen",    64'(dc_if.dcache_tag_wen), 64'h2);
        chk("r1_tag_din",    64'(dc_if.dcache_tag_din), 64'({26'h048D159, 26'h0}));
        chk("r1_dirty_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd1);
        chk("r1_dirty_wen",  64'(dc_if.dcache_dirty_wen), 64'h78);
        chk("r1_dirty_din",  64'(dc_if.dcache_dirty_din), 64'h28);
        chk("r1_idx",        64'(dc_if.dcache_idx), 64'h1FF);
        arb_grnt = 1'b0;
        step();
        chk("r1_pulse_end",  64'(dc_if.dcache_dirty_gwen), 64'd0);
        chk("r1_tag_end",    64'(dc_if.dcache_tag_wen), 64'd0);
        chk("r1_idx_hold",   64'(dc_if.dcache_idx), 64'h1FF);
        chk("r1_idle",       64'(dbg_state), 64'd0);
        chk("r1_busy",       64'(busy), 64'd0);

        // ---------------- state change, grant after 4 cycles
        st_req_vld = 1'b1;
        st_req_idx = 9'd5;
        st_req_way = 1'b0;
        st_req_wen = 3'b100;
        st_req_din = 3'b100;
        #1;
        chk("s1_st_rdy",     64'(st_req_rdy), 64'd1);
        chk("s1_refill_rdy", 64'(refill_req_rdy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            st_req_vld = 1'b0;
            chk("s1_arb_wait", 64'(arb_req), 64'd1);
            chk("s1_no_write", 64'(dc_if.dcache_dirty_gwen), 64'd0);
        end
        arb_grnt = 1'b1;
        step();
        arb_grnt = 1'b0;
        chk("s1_dirty_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd1);
        chk("s1_dirty_wen",  64'(dc_if.dcache_dirty_wen), 64'h04);
        chk("s1_dirty_din",  64'(dc_if.dcache_dirty_din), 64'h04);
        chk("s1_tag_gwen",   64'(dc_if.dcache_tag_gwen), 64'd0);
        chk("s1_tag_wen",    64'(dc_if.dcache_tag_wen), 64'd0);
        chk("s1_idx",        64'(dc_if.dcache_idx), 64'd5);
        step();
        chk("s1_single",     64'(dc_if.dcache_dirty_gwen), 64'd0);

        // ---------------- simultaneous refill and state change
        refill_req_vld   = 1'b1;
        refill_req_addr  = 40'h00_0000_4040;
        refill_req_way   = 1'b0;
        refill_req_dirty = 1'b0;
        refill_req_share = 1'b1;
        st_req_vld       = 1'b1;
        st_req_idx       = 9'd9;
        st_req_way       = 1'b1;
        st_req_wen       = 3'b011;
        st_req_din       = 3'b001;
        arb_grnt         = 1'b1;
        #1;
        chk("p_refill_rdy", 64'(refill_req_rdy), 64'd1);
        chk("p_st_rdy",     64'(st_req_rdy), 64'd0);
        step();
        refill_req_vld = 1'b0;
        chk("p_st_rdy_arb", 64'(st_req_rdy), 64'd0);
        step();
        chk("p_r_tag_wen",   64'(dc_if.dcache_tag_wen), 64'h1);
        chk("p_r_tag_din",   64'(dc_if.dcache_tag_din), 64'h1);
        chk("p_r_dirty_wen", 64'(dc_if.dcache_dirty_wen), 64'h47);
        chk("p_r_dirty_din", 64'(dc_if.dcache_dirty_din), 64'h43);
        chk("p_r_idx",       64'(dc_if.dcache_idx), 64'h101);
        step();
        chk("p_st_rdy_idle", 64'(st_req_rdy), 64'd1);
        step();
        st_req_vld = 1'b0;
        step();
        chk("p_s_dirty_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd1);
        chk("p_s_tag_gwen",   64'(dc_if.dcache_tag_gwen), 64'd0);
        chk("p_s_dirty_wen",  64'(dc_if.dcache_dirty_wen), 64'h18);
        chk("p_s_dirty_din",  64'(dc_if.dcache_dirty_din), 64'h08);
        chk("p_s_idx",        64'(dc_if.dcache_idx), 64'd9);
        arb_grnt = 1'b0;
        step();
        chk("p_idle", 64'(busy), 64'd0);

        // ---------------- full sweep with grant toggling
        for (int i = 0; i < 512; i++) exp_q.push_back(9'(i));
        inv_all_req = 1'b1;
        step();
        inv_all_req = 1'b0;
        chk("sw_busy_pending", 64'(busy), 64'd1);
        chk("sw_no_rdy",       64'(refill_req_rdy), 64'd0);
        cyc      = 0;
        done_cnt = 0;
        g        = 1'b0;
        finished = 1'b0;
        while (!finished && cyc < 3000) begin
            if (inv_all_done) done_cnt++;
            if (dc_if.dcache_dirty_gwen) begin
                e = exp_q.pop_front();
                chk("sw_idx",       64'(dc_if.dcache_idx), 64'(e));
                chk("sw_dirty_wen", 64'(dc_if.dcache_dirty_wen), 64'h3F);
                chk("sw_dirty_din", 64'(dc_if.dcache_dirty_din), 64'h00);
                chk("sw_tag_gwen",  64'(dc_if.dcache_tag_gwen), 64'd0);
                chk("sw_done",      64'(inv_all_done), 64'(e == 9'd511));
                if (e == 9'd511 || exp_q.size() == 0) finished = 1'b1;
            end
            if (!finished) begin
                g        = ~g;
                arb_grnt = g;
                step();
                cyc++;
            end
        end
        arb_grnt = 1'b0;
        chk("sw_finished",  64'(finished), 64'd1);
        chk("sw_all_idx",   64'(exp_q.size()), 64'd0);
        chk("sw_done_once", 64'(done_cnt), 64'd1);
        step();
        chk("sw_busy_end",  64'(busy), 64'd0);
        chk("sw_state_end", 64'(dbg_state), 64'd0);
        chk("sw_done_end",  64'(inv_all_done), 64'd0);
        chk("sw_gwen_end",  64'(dc_if.dcache_dirty_gwen), 64'd0);

        // ---------------- inv_all during ARB of a refill
        refill_req_vld   = 1'b1;
        refill_req_addr  = 40'h00_0000_8080;
        refill_req_way   = 1'b1;
        refill_req_dirty = 1'b0;
        refill_req_share = 1'b0;
        step();
        refill_req_vld = 1'b0;
        inv_all_req    = 1'b1;
        chk("ia_arb", 64'(dbg_state), 64'd1);
        step();
        inv_all_req = 1'b0;
        arb_grnt    = 1'b1;
        chk("ia_busy", 64'(busy), 64'd1);
        step();
        chk("ia_refill_tag_gwen", 64'(dc_if.dcache_tag_gwen), 64'd1);
        chk("ia_refill_wen",      64'(dc_if.dcache_dirty_wen), 64'h78);
        chk("ia_refill_din",      64'(dc_if.dcache_dirty_din), 64'h08);
        chk("ia_refill_idx",      64'(dc_if.dcache_idx), 64'h002);
        step();
        exp_i    = 0;
        cyc      = 0;
        finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (dc_if.dcache_dirty_gwen) begin
                chk("ia_sweep_idx", 64'(dc_if.dcache_idx), 64'(exp_i));
                chk("ia_sweep_tag", 64'(dc_if.dcache_tag_gwen), 64'd0);
                if (exp_i == 100) finished = 1'b1;
                else exp_i++;
            end
            if (!finished) begin
                step();
                cyc++;
            end
        end
        chk("ia_reached_100", 64'(finished), 64'd1);

        // ---------------- asynchronous reset at sweep idx 100
        rst_n = 1'b0;
        #1;
        chk("ar_dirty_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd0);
        chk("ar_dirty_wen",  64'(dc_if.dcache_dirty_wen), 64'd0);
        chk("ar_idx",        64'(dc_if.dcache_idx), 64'd0);
        chk("ar_tag_gwen",   64'(dc_if.dcache_tag_gwen), 64'd0);
        chk("ar_done",       64'(inv_all_done), 64'd0);
        chk("ar_arb_req",    64'(arb_req), 64'd0);
        chk("ar_busy",       64'(busy), 64'd0);
        chk("ar_state",      64'(dbg_state), 64'd0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_post_done", 64'(inv_all_done), 64'd0);
            chk("ar_post_busy", 64'(busy), 64'd0);
            chk("ar_post_gwen", 64'(dc_if.dcache_dirty_gwen), 64'd0);
        end
        inv_all_req = 1'b1;
        step();
        inv_all_req = 1'b0;
        cyc      = 0;
        finished = 1'b0;
        while (!finished && cyc < 20) begin
            if (dc_if.dcache_dirty_gwen) begin
                chk("ar_restart_idx",  64'(dc_if.dcache_idx), 64'd0);
                chk("ar_restart_done", 64'(inv_all_done), 64'd0);
                finished = 1'b1;
            end else begin
                step();
                cyc++;
            end
        end
        chk("ar_restart_seen", 64'(finished), 64'd1);
        step();
        chk("ar_second_idx", 64'(dc_if.dcache_idx), 64'd1);
        arb_grnt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_lsu_dcache_info_writer.md
Name: ct_lsu_dcache_info_writer

Overview:
Drives the dcache tag and dirty array write interface: tag/dirty gwen, wen, din and index. It is the producer side of the bus that dcache info snoopers watch to keep their way/dirty/share/valid copies current. It serialises three request sources (refill, state change, invalidate-all sweep), requests the dcache array arbiter, and issues one-cycle write pulses. Sits in the LSU next to the refill buffer and snoop control.

Parameters:
IDX_W, 9, dcache index width (64K config; 8 for 32K)
TAG_W, 26, tag bits per way, taken from addr[39:14]

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
refill_req_vld  in  1  refill write request
refill_req_addr  in  40  refill line physical address
refill_req_way  in  1  victim way
refill_req_dirty  in  1  dirty state of the new line
refill_req_share  in  1  share state of the new line
refill_req_rdy  out  1  refill request accepted this cycle
st_req_vld  in  1  state-change request
st_req_idx  in  IDX_W  target index
st_req_way  in  1  target way
st_req_wen  in  3  bit enables {dirty,share,valid}
st_req_din  in  3  new {dirty,share,valid}
st_req_rdy  out  1  state-change request accepted this cycle
inv_all_req  in  1  pulse: invalidate the whole cache
inv_all_done  out  1  one-cycle pulse when the sweep completes
arb_req  out  1  array arbiter request
arb_grnt  in  1  array arbiter grant
dcache_idx  out  IDX_W  write index
dcache_tag_gwen  out  1  tag write valid
dcache_tag_wen  out  2  per-way tag enable
dcache_tag_din  out  52  {way1 tag, way0 tag}
dcache_dirty_gwen  out  1  dirty array write valid
dcache_dirty_wen  out  7  {lru, way1 d/s/v, way0 d/s/v}
dcache_dirty_din  out  7  same layout as dcache_dirty_wen
busy  out  1  state != IDLE or inv_all pending

Behaviour:
- Reset: state IDLE, sweep counter 0, inv_all pending flag 0, all outputs 0.
- All array outputs are registered. Outside a write pulse, gwen/wen/din are 0 and dcache_idx holds its last value.
- FSM states IDLE, ARB, WRITE, SWEEP.
- IDLE:
  - inv_all pending has highest priority -> SWEEP.
  - Otherwise refill_req_vld -> latch the payload, pulse refill_req_rdy, go to ARB.
  - Otherwise st_req_vld -> latch, pulse st_req_rdy, go to ARB.
  - rdy is only ever high in IDLE and is combinational on vld.
- ARB: arb_req=1. On arb_grnt=1, go to WRITE. The write pulse appears in the next cycle, so latency is 1 cycle from the grant cycle.
- WRITE: the single-cycle pulse, then return to IDLE. Minimum request-to-request spacing is 3 cycles.
- Refill write:
  - tag_gwen=1; tag_wen one-hot on way; din slice of that way = addr[39:14], the other slice 0.
  - dirty_gwen=1; wen = way slice 3'b111 plus bit6.
  - din slice = {dirty, share, 1}; bit6 = !way (LRU points to the other way).
  - idx = addr[14:6].
- State-change write:
  - tag_gwen=0, tag_wen=0; dirty_gwen=1.
  - wen slice = st_req_wen; din slice = st_req_din; bit6 wen=0.
  - If st_req_wen==0, the pulse is still issued as a harmless write.
- SWEEP:
  - arb_req held high. For each grant cycle, the next cycle writes idx=counter with dirty_gwen=1, wen=7'b0111111, din=0, tag_gwen=0, then counter increments.
  - Grant may drop at any cycle; the sweep stalls without skipping an index.
  - After writing index 2^IDX_W-1: counter wraps to 0, inv_all_done pulses in the same cycle as the last write, pending flag clears, go to IDLE.
- inv_all_req in any non-IDLE state sets the pending flag; the current operation finishes first.
- inv_all_req during SWEEP sets the flag again, giving one further full sweep after the current one (not merged).
- Simultaneous refill and state-change requests in IDLE: refill wins and st_req_rdy=0.
- Reset mid-sweep or mid-ARB aborts immediately: no write, no done, counter 0.

Decomposition:
- Shared LSU package holds:
  - state encoding
  - dirty-array bit layout constants (way0 [2:0], way1 [5:3], lru [6]; field order dirty/share/valid)
  - tag slice positions and the 32K/64K IDX_W selection
- Natural sub-module: ct_lsu_dcache_info_wr_fmt, a combinational formatter mapping a latched request kind/way/payload to tag/dirty wen/din vectors.

Test Plan:
- Refill addr=0x12_3456_7FC0, way1, dirty=1, share=0, grant immediately: one cycle later tag_wen=2'b10, tag_din[51:26]=addr[39:14], dirty_wen=7'h78, dirty_din=7'h28, idx=addr[14:6].
- State change idx=5, way0, wen=3'b100, din=3'b100, grant delayed 4 cycles: arb_req high for 4 cycles, then a single pulse with dirty_wen=7'h04, dirty_din=7'h04, tag_gwen=0.
- Refill and st_req both valid in IDLE: only refill_req_rdy pulses; st write follows after refill completes (st_req_vld held).
- inv_all_req with grant toggling every other cycle: 512 writes with idx 0..511 in order, none skipped, inv_all_done on the idx=511 write, busy then 0.
- inv_all_req during an ARB refill: refill write completes first, then the sweep starts from idx 0.
- Reset asserted at sweep idx 100: all outputs 0 asynchronously; after release a new inv_all starts at idx 0; no stale done.
